// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer with a
// one-entry valid/ready output buffer towards decode.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              pcNewFlag_i,
    input  logic [ADDR_W-1:0] PC_i,
    input  logic              stall_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] instPc_o,
    input  logic              inst_ready_i
);

    // WAIT keeps the returning data; DRAIN throws away data of a request
    // that was overtaken by a redirect while still in flight.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              valid_d;
    logic [INST_W-1:0] inst_d;
    logic [ADDR_W-1:0] inst_pc_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = imem_req_o;
        addr_d    = imem_addr_o;
        valid_d   = inst_valid_o;
        inst_d    = inst_o;
        inst_pc_d = instPc_o;

        case (state_q)
            S_IDLE: begin
                if (pcNewFlag_i) begin
                    pc_d    = PC_i;
                    valid_d = 1'b0;
                end else if (!stall_i && (!inst_valid_o || inst_ready_i)) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end else if (inst_valid_o && inst_ready_i) begin
                    valid_d = 1'b0;
                end
            end

            // Buffer is always empty here, so decode readiness is irrelevant.
            S_WAIT: begin
                if (imem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    if (pcNewFlag_i) begin
                        pc_d = PC_i;
                    end else begin
                        inst_d    = imem_data_i;
                        inst_pc_d = imem_addr_o;
                        valid_d   = 1'b1;
                        pc_d      = imem_addr_o + PC_STEP;
                    end
                end else if (pcNewFlag_i) begin
                    pc_d    = PC_i;
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (pcNewFlag_i) begin
                    pc_d = PC_i;
                end
                if (imem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            imem_req_o   <= 1'b0;
            imem_addr_o  <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            instPc_o     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_req_o   <= req_d;
            imem_addr_o  <= addr_d;
            inst_valid_o <= valid_d;
            inst_o       <= inst_d;
            instPc_o     <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written reset/wrap
// sequences, and randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redir;
    logic [15:0] pc_in;
    logic        stall;
    logic        ack;
    logic [15:0] data;
    logic        ready;

    logic        req, valid;
    logic [15:0] addr, inst, ipc;
    logic        hi_req, hi_valid;
    logic [15:0] hi_addr, hi_inst, hi_ipc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_unit u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .pcNewFlag_i(redir), .PC_i(pc_in),
        .stall_i(stall), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_data_i(data), .inst_valid_o(valid),
        .inst_o(inst), .instPc_o(ipc), .inst_ready_i(ready)
    );

    pc_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_hi (
        .clk_i(clk), .rst_n_i(rst_n), .pcNewFlag_i(redir), .PC_i(pc_in),
        .stall_i(stall), .imem_req_o(hi_req), .imem_addr_o(hi_addr),
        .imem_ack_i(ack), .imem_data_i(data), .inst_valid_o(hi_valid),
        .inst_o(hi_inst), .instPc_o(hi_ipc), .inst_ready_i(ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] p, input logic s,
                         input logic a, input logic [15:0] d, input logic rd);
        redir = r; pc_in = p; stall = s; ack = a; data = d; ready = rd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        redir;
        logic [15:0] pc_in;
        logic        stall;
        logic        ack;
        logic [15:0] data;
        logic        ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_inst;
        logic [15:0] e_ipc;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    // ---------------- reference model ----------------
    // Fetch-level view: one request in flight or not, a flag saying whether
    // its data is still wanted, and the buffered instruction for decode.
    logic [15:0] m_pc, m_addr, m_inst, m_ipc;
    logic        m_busy, m_stale, m_valid;

    task automatic model_reset(input logic [15:0] rpc);
        m_pc = rpc; m_addr = 16'h0; m_inst = 16'h0; m_ipc = 16'h0;
        m_busy = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (redir) begin
                m_pc = pc_in;
                m_valid = 1'b0;
            end else if (!stall && (!m_valid || ready)) begin
                m_valid = 1'b0;
                m_busy  = 1'b1;
                m_stale = 1'b0;
                m_addr  = m_pc;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end else begin
            if (redir) m_pc = pc_in;
            if (ack) begin
                if (!redir && !m_stale) begin
                    m_inst  = data;
                    m_ipc   = m_addr;
                    m_valid = 1'b1;
                    m_pc    = m_addr + 16'd1;
                end
                m_busy = 1'b0;
            end else if (redir) begin
                m_stale = 1'b1;
            end
        end
    endtask

    initial begin
        // {redir, pc_in, stall, ack, data, ready, e_req, e_addr, e_valid, e_inst, e_ipc}
        vecs[0]  = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[1]  = '{0, 16'h0000, 0, 1, 16'hA000, 1,  0, 16'h0000, 1, 16'hA000, 16'h0000};
        vecs[2]  = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0001, 0, 16'hA000, 16'h0000};
        vecs[3]  = '{0, 16'h0000, 0, 1, 16'hA001, 1,  0, 16'h0001, 1, 16'hA001, 16'h0001};
        vecs[4]  = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0002, 0, 16'hA001, 16'h0001};
        vecs[5]  = '{0, 16'h0000, 0, 1, 16'hA002, 1,  0, 16'h0002, 1, 16'hA002, 16'h0002};
        for (int i = 6; i <= 10; i++)
            vecs[i] = '{0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0002, 1, 16'hA002, 16'h0002};
        vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0003, 0, 16'hA002, 16'h0002};
        vecs[12] = '{1, 16'h0040, 0, 0, 16'h0000, 1,  1, 16'h0003, 0, 16'hA002, 16'h0002};
        vecs[13] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0003, 0, 16'hA002, 16'h0002};
        vecs[14] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0003, 0, 16'hA002, 16'h0002};
        vecs[15] = '{0, 16'h0000, 0, 1, 16'hDEAD, 1,  0, 16'h0003, 0, 16'hA002, 16'h0002};
        vecs[16] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0040, 0, 16'hA002, 16'h0002};
        vecs[17] = '{0, 16'h0000, 0, 1, 16'hB040, 1,  0, 16'h0040, 1, 16'hB040, 16'h0040};
        vecs[18] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0041, 0, 16'hB040, 16'h0040};
        vecs[19] = '{1, 16'h0040, 0, 1, 16'hBEEF, 1,  0, 16'h0041, 0, 16'hB040, 16'h0040};
        vecs[20] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0040, 0, 16'hB040, 16'h0040};
        vecs[21] = '{0, 16'h0000, 0, 1, 16'hC040, 1,  0, 16'h0040, 1, 16'hC040, 16'h0040};
        vecs[22] = '{0, 16'h0000, 1, 0, 16'h0000, 1,  0, 16'h0040, 0, 16'hC040, 16'h0040};
        vecs[23] = '{0, 16'h0000, 1, 1, 16'hEEEE, 1,  0, 16'h0040, 0, 16'hC040, 16'h0040};
        vecs[24] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0041, 0, 16'hC040, 16'h0040};
        vecs[25] = '{0, 16'h0000, 1, 1, 16'hD041, 1,  0, 16'h0041, 1, 16'hD041, 16'h0041};
        vecs[26] = '{1, 16'h0100, 0, 0, 16'h0000, 0,  0, 16'h0041, 0, 16'hD041, 16'h0041};
        vecs[27] = '{0, 16'h0000, 0, 0, 16'h0000, 1,  1, 16'h0100, 0, 16'hD041, 16'h0041};

        rst_n = 1'b0;
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        do_reset();

        check("reset req",   req,   1'b0);
        check("reset addr",  addr,  16'h0);
        check("reset valid", valid, 1'b0);
        check("reset inst",  inst,  16'h0);
        check("reset ipc",   ipc,   16'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].redir, vecs[i].pc_in, vecs[i].stall,
                  vecs[i].ack, vecs[i].data, vecs[i].ready);
            step();
            check($sformatf("vec%0d req", i),   req,   vecs[i].e_req);
            check($sformatf("vec%0d addr", i),  addr,  vecs[i].e_addr);
            check($sformatf("vec%0d valid", i), valid, vecs[i].e_valid);
            check($sformatf("vec%0d inst", i),  inst,  vecs[i].e_inst);
            check($sformatf("vec%0d ipc", i),   ipc,   vecs[i].e_ipc);
        end

        // RESET_PC=FFFF wraps to 0000; stall in IDLE holds off the next fetch.
        do_reset();
        drive(0, 16'h0, 0, 0, 16'h0, 1);
        step();
        check("wrap req0",  hi_req,  1'b1);
        check("wrap addr0", hi_addr, 16'hFFFF);
        drive(0, 16'h0, 0, 1, 16'h5A5A, 1);
        step();
        check("wrap valid", hi_valid, 1'b1);
        check("wrap ipc",   hi_ipc,   16'hFFFF);
        check("wrap inst",  hi_inst,  16'h5A5A);
        drive(0, 16'h0, 1, 0, 16'h0, 1);
        step();
        check("stall req a", hi_req, 1'b0);
        step();
        check("stall req b", hi_req, 1'b0);
        drive(0, 16'h0, 0, 0, 16'h0, 1);
        step();
        check("wrap req1",  hi_req,  1'b1);
        check("wrap addr1", hi_addr, 16'h0000);

        // Asynchronous reset while a request is outstanding.
        drive(0, 16'h0, 0, 0, 16'h0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async req",     req,    1'b0);
        check("async hi req",  hi_req, 1'b0);
        check("async valid",   valid,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post-reset req",     req,     1'b1);
        check("post-reset addr",    addr,    16'h0000);
        check("post-reset hi addr", hi_addr, 16'hFFFF);

        // Asynchronous reset while the output buffer is full and stalled.
        drive(0, 16'h0, 0, 1, 16'h7777, 0);
        step();
        check("buf full", valid, 1'b1);
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("async buf valid", valid, 1'b0);
        check("async buf inst",  inst,  16'h0);

        // Randomized traffic against the model.
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(16'h0000);
        for (int c = 0; c < 800; c++) begin
            redir = ($urandom_range(0, 99) < 12);
            pc_in = 16'($urandom);
            stall = ($urandom_range(0, 99) < 20);
            ready = ($urandom_range(0, 99) < 70);
            data  = 16'($urandom);
            if (req) ack = ($urandom_range(0, 1) == 1);
            else     ack = ($urandom_range(0, 9) == 0);
            model_step();
            step();
            check($sformatf("rnd%0d req", c),   req,   m_busy);
            check($sformatf("rnd%0d addr", c),  addr,  m_addr);
            check($sformatf("rnd%0d valid", c), valid, m_valid);
            check($sformatf("rnd%0d inst", c),  inst,  m_inst);
            check($sformatf("rnd%0d ipc", c),   ipc,   m_ipc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
